// File: rtl/wall_scroll_ctrl.sv
// Striped wall renderer: on each accepted tick, draws one scroll phase of the wall pixel by pixel.
// Define WALL_DUAL_SIDE_EN to also mirror every pixel onto the right wall at X_RIGHT.
module wall_scroll_ctrl #(
    parameter int             ROWS      = 120,
    parameter int             COLS      = 2,
    parameter int             PHASES    = 5,
    parameter int             PERIOD    = 8,
    parameter int             STRIPE_ON = 4,
    parameter int             X_LEFT    = 0,
    parameter int             X_RIGHT   = 158,
    parameter int             Y_TOP     = 0,
    parameter logic [2:0]     COLOR_ON  = 3'b111,
    parameter logic [2:0]     COLOR_OFF = 3'b000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       tick,
    input  logic       enable,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done,
    output logic       overrun
);

    // state    | meaning
    // ST_WAIT  | idle, waiting for tick with enable high
    // ST_DRAW  | emitting one pixel per cycle for the current phase
    // ST_DONE  | one-cycle completion pulse, phase advances
    typedef enum logic [1:0] {ST_WAIT, ST_DRAW, ST_DONE} state_t;

    localparam int         PB       = $clog2(PERIOD);
    localparam logic [6:0] ROW_LAST = 7'(ROWS - 1);
    localparam logic [2:0] COL_LAST = 3'(COLS - 1);
    localparam logic [3:0] PH_LAST  = 4'(PHASES - 1);
    localparam logic [7:0] XL       = 8'(X_LEFT);
    localparam logic [6:0] YT       = 7'(Y_TOP);

    generate
        if (ROWS < 1 || ROWS > 128 || COLS < 1 || COLS > 8 || PHASES < 1 || PHASES > 16 ||
            PERIOD < 2 || PERIOD > 128 || (PERIOD & (PERIOD - 1)) != 0 ||
            STRIPE_ON < 1 || STRIPE_ON >= PERIOD || X_RIGHT < 0 || X_RIGHT > 255) begin : g_bad_params
            $error("wall_scroll_ctrl: parameter out of range");
        end
    endgenerate

    state_t     state, state_nxt;
    logic [6:0] row;
    logic [2:0] col;
    logic [3:0] phase;
    logic       step_pix;
    logic       last_pix;
    logic [PB-1:0] stripe_pos;

`ifdef WALL_DUAL_SIDE_EN
    localparam logic [7:0] XR = 8'(X_RIGHT);
    logic side;

    // Row/col only move after the right-wall copy of a pixel has been drawn.
    assign step_pix = side;
`else
    assign step_pix = 1'b1;
`endif

    assign last_pix = (row == ROW_LAST) && (col == COL_LAST) && step_pix;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_WAIT: if (tick && enable) state_nxt = ST_DRAW;
            ST_DRAW: if (last_pix) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_WAIT;
            default: state_nxt = ST_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= ST_WAIT;
            row     <= '0;
            col     <= '0;
            phase   <= '0;
            overrun <= 1'b0;
`ifdef WALL_DUAL_SIDE_EN
            side    <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (tick && (state != ST_WAIT))
                overrun <= 1'b1;
`ifdef WALL_DUAL_SIDE_EN
            if (state == ST_DRAW)
                side <= ~side;
`endif
            if ((state == ST_DRAW) && step_pix) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 7'd1;
                end else begin
                    col <= col + 3'd1;
                end
            end
            if (state == ST_DONE)
                phase <= (phase == PH_LAST) ? '0 : phase + 4'd1;
        end
    end

    assign plot = (state == ST_DRAW);
    assign busy = (state == ST_DRAW) || (state == ST_DONE);
    assign done = (state == ST_DONE);

    // Truncation to PB bits is the modulo-PERIOD operation.
    assign stripe_pos = PB'(row) + PB'(phase);
    assign colour = (plot && (int'(stripe_pos) < STRIPE_ON)) ? COLOR_ON : COLOR_OFF;

`ifdef WALL_DUAL_SIDE_EN
    assign x = (side ? XR : XL) + {5'b0, col};
`else
    assign x = XL + {5'b0, col};
`endif
    assign y = YT + row;

endmodule

// File: tb/tb_wall_scroll_ctrl.sv
// Directed bench for wall_scroll_ctrl at default parameters; follows WALL_DUAL_SIDE_EN if defined.
module tb_wall_scroll_ctrl;

    localparam int ROWS = 120;
    localparam int COLS = 2;
`ifdef WALL_DUAL_SIDE_EN
    localparam int SIDES = 2;
`else
    localparam int SIDES = 1;
`endif
    localparam int NPIX = ROWS * COLS * SIDES;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       tick = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot, busy, done, overrun;

    int checks = 0;
    int errors = 0;

    wall_scroll_ctrl dut (
        .clk(clk), .resetn(resetn), .tick(tick), .enable(enable),
        .x(x), .y(y), .colour(colour), .plot(plot),
        .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; tick = 1'b0; enable = 1'b0;
        step(); step();
        checks++; if (plot !== 1'b0)    begin errors++; $display("FAIL reset_plot got %0b want 0", plot); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done got %0b want 0", done); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %0b want 0", overrun); end
        checks++; if (x !== 8'd0)       begin errors++; $display("FAIL reset_x got %0d want 0", x); end
        checks++; if (y !== 7'd0)       begin errors++; $display("FAIL reset_y got %0d want 0", y); end
        checks++; if (colour !== 3'd0)  begin errors++; $display("FAIL reset_colour got %0d want 0", colour); end
        resetn = 1'b1;
        step();
    endtask

    // Accept one tick, then check every pixel of the phase against the scan/stripe model.
    task automatic run_phase(input int p, input int enable_drop_at, input int tick_at);
        int i;
        int pair, side, row, col;
        logic [7:0] ex;
        logic [6:0] ey;
        logic [2:0] ec;
        enable = 1'b1; tick = 1'b1;
        step();
        tick = 1'b0;
        i = 0;
        while (plot === 1'b1 && i < 2 * NPIX) begin
            pair = i / SIDES;
            side = i % SIDES;
            row  = pair / COLS;
            col  = pair % COLS;
            ex = 8'((side == 1 ? 158 : 0) + col);
            ey = 7'(row);
            ec = (((row + p) % 8) < 4) ? 3'd7 : 3'd0;
            checks++; if (x !== ex)      begin errors++; $display("FAIL ph%0d_x pix %0d got %0d want %0d", p, i, x, ex); end
            checks++; if (y !== ey)      begin errors++; $display("FAIL ph%0d_y pix %0d got %0d want %0d", p, i, y, ey); end
            checks++; if (colour !== ec) begin errors++; $display("FAIL ph%0d_colour pix %0d got %0d want %0d", p, i, colour, ec); end
            checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL ph%0d_busy pix %0d got busy=%0b done=%0b want 1/0", p, i, busy, done); end
            if (i == enable_drop_at) enable = 1'b0;
            if (i == tick_at) tick = 1'b1;
            step();
            tick = 1'b0;
            i++;
        end
        checks++; if (i != NPIX) begin errors++; $display("FAIL ph%0d_plot_count got %0d want %0d", p, i, NPIX); end
        checks++; if (done !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL ph%0d_done_pulse got done=%0b busy=%0b want 1/1", p, done, busy); end
        checks++; if (colour !== 3'd0) begin errors++; $display("FAIL ph%0d_done_colour got %0d want 0", p, colour); end
        step();
        checks++; if (done !== 1'b0 || busy !== 1'b0 || plot !== 1'b0) begin errors++; $display("FAIL ph%0d_idle got done=%0b busy=%0b plot=%0b want 0/0/0", p, done, busy, plot); end
        enable = 1'b1;
    endtask

    task automatic test_phase_sequence();
        for (int p = 0; p < 5; p++) run_phase(p, -1, -1);
        run_phase(0, -1, -1);
    endtask

    task automatic test_enable_gate();
        enable = 1'b0; tick = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if (plot !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL enable_gate cyc %0d got plot=%0b busy=%0b want 0/0", k, plot, busy); end
        end
        tick = 1'b0;
        step();
        run_phase(1, 10, -1);
    endtask

    task automatic test_overrun();
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_pre got %0b want 0", overrun); end
        run_phase(2, -1, 100);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got %0b want 1", overrun); end
        repeat (3) begin
            step();
            checks++; if (plot !== 1'b0) begin errors++; $display("FAIL overrun_no_extra got plot=%0b want 0", plot); end
        end
        run_phase(3, -1, -1);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky got %0b want 1", overrun); end
    endtask

    task automatic test_reset_mid_draw();
        enable = 1'b1; tick = 1'b1;
        step();
        tick = 1'b0;
        repeat (50) step();
        checks++; if (plot !== 1'b1) begin errors++; $display("FAIL mid_pre_plot got %0b want 1", plot); end
        resetn = 1'b0;
        step();
        checks++; if (plot !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_reset got plot=%0b busy=%0b want 0/0", plot, busy); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL mid_reset_overrun got %0b want 0", overrun); end
        resetn = 1'b1;
        repeat (3) begin
            step();
            checks++; if (plot !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_after got plot=%0b busy=%0b want 0/0", plot, busy); end
        end
        run_phase(0, -1, -1);
    endtask

    initial begin
        test_reset();
        test_phase_sequence();
        test_enable_gate();
        test_overrun();
        test_reset_mid_draw();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
